// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial shift register stage and the
// word assembler.
package shift_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'b1011;
    localparam int         WORD_W_DEF  = 8;

endpackage : shift_pkg

// File: rtl/word_fifo.sv
// Small synchronous FIFO with a registered head word (dout) and an occupancy
// count that tells full apart from empty.
module word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + PTR_W'(1);

    // NOTE: storage has no reset; dout and count decide what is visible, so
    // clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_next;

            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Head follows the next stored entry, or the incoming word when
            // nothing else is queued behind it.
            if (empty && do_push) begin
                dout <= din;
            end else if (do_pop) begin
                if (count >= CNT_W'(2)) begin
                    dout <= mem[rd_next];
                end else if (do_push) begin
                    dout <= din;
                end
            end
        end
    end

endmodule : word_fifo

// File: rtl/shift_word_assembler.sv
// Hunts a serial bit stream for a sync nibble, assembles the following
// WORD_W bits in the latched bit order and queues finished words.
module shift_word_assembler
    import shift_pkg::*;
#(
    parameter int         WORD_W       = WORD_W_DEF,
    parameter logic [3:0] SYNC_PATTERN = SYNC_NIBBLE,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              dir_in,
    input  logic              clear,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              sync_locked,
    output logic              overflow
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            state_q;
    logic [3:0]        window_q;
    logic [3:0]        window_next;
    logic [2:0]        hunt_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_idx;
    logic              dir_q;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next;
    logic              sync_hit;
    logic              last_bit;
    logic              frame_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              push_rejected;

    assign window_next = {window_q[2:0], bit_in};
    // The current bit counts toward the four needed since entering HUNT.
    assign sync_hit    = (window_next == SYNC_PATTERN) && (hunt_cnt_q >= 3'd3);
    assign last_bit    = (bit_cnt_q == CNT_W'(WORD_W - 1));
    assign bit_idx     = dir_q ? (CNT_W'(WORD_W - 1) - bit_cnt_q) : bit_cnt_q;
    assign frame_done  = bit_valid && (state_q == COLLECT) && last_bit && !clear;

    assign word_valid    = !fifo_empty;
    assign fifo_pop      = word_valid && word_ready;
    assign push_rejected = frame_done && fifo_full && !fifo_pop;

    // NOTE: asm_next takes its full default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        asm_next = asm_q;
        if ((state_q == COLLECT) && bit_valid) begin
            asm_next[bit_idx] = bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            window_q    <= '0;
            hunt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            dir_q       <= 1'b0;
            asm_q       <= '0;
            sync_locked <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state_q     <= HUNT;
            window_q    <= '0;
            hunt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sync_locked <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_rejected) overflow <= 1'b1;

            if (bit_valid) begin
                unique case (state_q)
                    HUNT: begin
                        window_q <= window_next;
                        if (hunt_cnt_q != 3'd4) hunt_cnt_q <= hunt_cnt_q + 3'd1;
                        if (sync_hit) begin
                            state_q     <= COLLECT;
                            sync_locked <= 1'b1;
                            dir_q       <= dir_in;
                            bit_cnt_q   <= '0;
                        end
                    end
                    COLLECT: begin
                        asm_q <= asm_next;
                        if (last_bit) begin
                            // Frames never overlap: the hunt restarts from scratch.
                            state_q     <= HUNT;
                            sync_locked <= 1'b0;
                            window_q    <= '0;
                            hunt_cnt_q  <= '0;
                            bit_cnt_q   <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (frame_done),
        .din   (asm_next),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (word_data),
        .empty (fifo_empty)
    );

endmodule : shift_word_assembler

// File: tb/tb_shift_word_assembler.sv
// Self-checking bench: directed frames plus random traffic compared every
// cycle against a queue-based model of the framing and buffering rules.
module tb_shift_word_assembler;

    localparam int         WORD_W = 8;
    localparam int         DEPTH  = 4;
    localparam logic [3:0] SYNC   = 4'b1011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bit_valid;
    logic              bit_in;
    logic              dir_in;
    logic              clear;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              sync_locked;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    bit             m_locked;
    bit             m_dir;
    bit             m_ovf;
    bit             m_hist[$];
    bit             m_data[$];
    logic [7:0]     m_fifo[$];

    always #5 clk = ~clk;

    shift_word_assembler #(
        .WORD_W       (WORD_W),
        .SYNC_PATTERN (SYNC),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .dir_in      (dir_in),
        .clear       (clear),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sync_locked (sync_locked),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_dir    = 1'b0;
        m_ovf    = 1'b0;
        m_hist.delete();
        m_data.delete();
        m_fifo.delete();
    endtask

    // One clock of the reference: uses the inputs that were applied at the edge.
    task automatic model_step();
        bit         pop;
        bit         push;
        logic [7:0] w;
        pop  = (m_fifo.size() > 0) && word_ready;
        push = 1'b0;
        w    = '0;
        if (clear) begin
            model_reset();
        end else begin
            if (bit_valid) begin
                if (!m_locked) begin
                    m_hist.push_back(bit_in);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    if (m_hist.size() == 4 &&
                        {m_hist[0], m_hist[1], m_hist[2], m_hist[3]} == SYNC) begin
                        m_locked = 1'b1;
                        m_dir    = dir_in;
                        m_data.delete();
                    end
                end else begin
                    m_data.push_back(bit_in);
                    if (m_data.size() == WORD_W) begin
                        for (int i = 0; i < WORD_W; i++) begin
                            w = w | (8'(m_data[i]) << (m_dir ? (WORD_W - 1 - i) : i));
                        end
                        push     = 1'b1;
                        m_locked = 1'b0;
                        m_hist.delete();
                        m_data.delete();
                    end
                end
            end
            if (push && !(m_fifo.size() < DEPTH || pop)) m_ovf = 1'b1;
            if (pop) void'(m_fifo.pop_front());
            if (push && (m_fifo.size() < DEPTH)) m_fifo.push_back(w);
        end
    endtask

    task automatic compare_all();
        check("word_valid", word_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("word_data", word_data, m_fifo[0]);
        check("sync_locked", sync_locked, m_locked);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic bv, input logic b, input logic d,
                        input logic clr, input logic rdy);
        bit_valid  = bv;
        bit_in     = b;
        dir_in     = d;
        clear      = clr;
        word_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_sync(input logic d, input logic rdy);
        logic [3:0] s;
        s = SYNC;
        for (int i = 0; i < 4; i++) step(1'b1, s[3-i], d, 1'b0, rdy);
    endtask

    // seq[7] is the first bit on the wire.
    task automatic send_seq(input logic [7:0] seq, input logic d, input logic rdy);
        for (int i = 0; i < 8; i++) step(1'b1, seq[7-i], d, 1'b0, rdy);
    endtask

    task automatic send_word(input logic [7:0] v, input logic d,
                             input logic rdy, input logic last_rdy);
        send_sync(d, rdy);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, d ? v[7-i] : v[i], d, 1'b0, (i == 7) ? last_rdy : rdy);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] noise;
        rst_n      = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        dir_in     = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        model_reset();
        #12;
        check("rst_word_data", word_data, 8'h00);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_sync_locked", sync_locked, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, LSB-first.
        send_sync(1'b0, 1'b0);
        check("locked_after_sync", sync_locked, 1'b1);
        send_seq(8'b10100101, 1'b0, 1'b0);
        check("a5_lsb_valid", word_valid, 1'b1);
        check("a5_lsb_data", word_data, 8'hA5);
        check("a5_lsb_unlocked", sync_locked, 1'b0);
        drain();
        check("drained", word_valid, 1'b0);

        // Bit-order cases.
        send_sync(1'b1, 1'b0);
        send_seq(8'b10100101, 1'b1, 1'b0);
        check("a5_msb_data", word_data, 8'hA5);
        drain();
        send_sync(1'b0, 1'b0);
        send_seq(8'b11000000, 1'b0, 1'b0);
        check("c0_lsb_data", word_data, 8'h03);
        drain();
        send_sync(1'b1, 1'b0);
        send_seq(8'b11000000, 1'b1, 1'b0);
        check("c0_msb_data", word_data, 8'hC0);
        drain();

        // Noise ahead of the sync nibble.
        noise = 8'b01101011;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, noise[7-i], 1'b0, 1'b0, 1'b0);
            if (i < 7) check("noise_no_lock", sync_locked, 1'b0);
        end
        check("noise_lock", sync_locked, 1'b1);
        send_seq(8'b00110101, 1'b0, 1'b0);
        check("noise_word", word_data, 8'hAC);
        drain();

        // Overflow with a stalled consumer.
        for (int v = 1; v <= 5; v++) send_word(8'(v), 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_pop_order", word_data, 32'(k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("ovf_empty", word_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_cleared", overflow, 1'b0);

        // Full FIFO with a pop in the cycle the fifth frame completes.
        for (int v = 1; v <= 4; v++) send_word(8'(v), 1'b0, 1'b0, 1'b0);
        send_word(8'h05, 1'b0, 1'b0, 1'b1);
        check("full_pop_no_ovf", overflow, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            check("full_pop_order", word_data, 32'(k));
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Clear in the middle of a frame.
        send_sync(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_unlocked", sync_locked, 1'b0);
        check("clr_no_word", word_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_rest_discarded", word_valid, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        check("clr_fresh_word", word_data, 8'h3C);
        drain();

        // Asynchronous reset in the middle of a frame, with a word buffered.
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_sync(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_unlocked", sync_locked, 1'b0);
        check("arst_no_word", word_valid, 1'b0);
        check("arst_data_zero", word_data, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("arst_rest_discarded", word_valid, 1'b0);
        send_word(8'h99, 1'b1, 1'b0, 1'b0);
        check("arst_fresh_word", word_data, 8'h99);
        drain();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shift_word_assembler
